// File: rtl/simd_mac_pipe.sv
// simd_mac_pipe
//   Three-stage pipelined signed multiply-accumulate with a full mode
//   (one DATA_W lane) and a split mode (LANES independent sub-lanes).
//   S1 registers the inputs, S2 registers the products, S3 is the
//   accumulator {protect, result} itself.
//
//   Optional feature macro: MAC_OVF_FLAG_EN
//     defined   -> sticky overflow flag on mac wrap, cleared by a clear op
//     undefined -> ovf is tied low and no overflow detect logic exists
//
//   LANES must be 1, 2 or 4 and must divide both DATA_W and GUARD_W.

module simd_mac_pipe #(
    parameter int DATA_W  = 16,
    parameter int LANES   = 2,
    parameter int GUARD_W = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  stall,
    input  logic                  in_valid,
    input  logic [2:0]            instruction,
    input  logic [DATA_W-1:0]     multiplier,
    input  logic [DATA_W-1:0]     multiplicand,
    output logic [2*DATA_W-1:0]   result,
    output logic [GUARD_W-1:0]    protect,
    output logic                  out_valid,
    output logic                  ovf
);

    // Lane geometry: body widths, guard widths and full accumulator widths
    localparam int LW  = DATA_W / LANES;
    localparam int GW  = GUARD_W / LANES;
    localparam int PW  = 2 * DATA_W;
    localparam int AW  = GUARD_W + PW;
    localparam int LPW = 2 * LW;
    localparam int LAW = GW + LPW;

    typedef enum logic [1:0] {
        OP_CLEAR = 2'b00,
        OP_LOAD  = 2'b01,
        OP_MAC   = 2'b10,
        OP_SAT   = 2'b11
    } op_e;

    // Stage 1: registered inputs
    logic              s1Valid_q;
    logic [2:0]        s1Instr_q;
    logic [DATA_W-1:0] s1Mplier_q;
    logic [DATA_W-1:0] s1Mcand_q;

    // Stage 2: registered products (full product or packed lane products)
    logic              s2Valid_q;
    logic [2:0]        s2Instr_q;
    logic [PW-1:0]     s2Prod_q;
    logic [PW-1:0]     s2Prod_d;

    // Stage 3: accumulator laid out as {protect, result}
    logic [AW-1:0]     acc_q;
    logic [AW-1:0]     acc_d;
    logic              outValid_q;

    // Product candidates computed from the S1 registers
    logic [PW-1:0]     fullProd;
    logic [PW-1:0]     laneProd;

    // Accumulator candidates for each mode
    logic [AW-1:0]     fullProdExt;
    logic [AW-1:0]     fullSum;
    logic [AW-1:0]     fullNext;
    logic [AW-1:0]     splitNext;

    op_e               s2Op;
    logic              s2Split;

    assign s2Op    = op_e'(s2Instr_q[1:0]);
    assign s2Split = s2Instr_q[2];

    // Operands are sign-extended to the product width so the low PW bits of
    // the multiply are the exact signed product.
    assign fullProd = $signed({{DATA_W{s1Mplier_q[DATA_W-1]}}, s1Mplier_q}) *
                      $signed({{DATA_W{s1Mcand_q[DATA_W-1]}}, s1Mcand_q});

    // Split mode packs each lane product into its own 2*LW slot
    assign s2Prod_d = s1Instr_q[2] ? laneProd : fullProd;

    assign fullProdExt = {{GUARD_W{s2Prod_q[PW-1]}}, s2Prod_q};
    assign fullSum     = acc_q + fullProdExt;

`ifdef MAC_OVF_FLAG_EN
    logic              ovf_q;
    logic              ovf_d;
    logic              fullWrap;
    logic [LANES-1:0]  splitWrap;

    // Signed wrap: both addends share a sign and the sum has the other one
    assign fullWrap = (acc_q[AW-1] == fullProdExt[AW-1]) &&
                      (fullSum[AW-1] != acc_q[AW-1]);
`endif

    // Per-lane product, accumulator view and next-value selection
    for (genvar i = 0; i < LANES; i++) begin : gLane
        logic [LAW-1:0] laneA;
        logic [LAW-1:0] laneP;
        logic [LAW-1:0] laneSum;
        logic [LAW-1:0] laneNext;

        assign laneProd[i*LPW +: LPW] =
            $signed({{LW{s1Mplier_q[i*LW+LW-1]}}, s1Mplier_q[i*LW +: LW]}) *
            $signed({{LW{s1Mcand_q[i*LW+LW-1]}}, s1Mcand_q[i*LW +: LW]});

        // A lane's guard bits live in protect, its body in result
        assign laneA   = {acc_q[PW+i*GW +: GW], acc_q[i*LPW +: LPW]};
        assign laneP   = {{GW{s2Prod_q[i*LPW+LPW-1]}}, s2Prod_q[i*LPW +: LPW]};
        assign laneSum = laneA + laneP;

        // Lane op: clear, load, wrap-around add or saturate to body range
        always_comb begin
            laneNext = laneA;
            case (s2Op)
                OP_CLEAR: laneNext = '0;
                OP_LOAD:  laneNext = laneP;
                OP_MAC:   laneNext = laneSum;
                OP_SAT: begin
                    if (!laneA[LAW-1] && (|laneA[LAW-2:LPW-1])) begin
                        laneNext = {{GW{1'b0}}, 1'b0, {(LPW-1){1'b1}}};
                    end else if (laneA[LAW-1] && !(&laneA[LAW-2:LPW-1])) begin
                        laneNext = {{GW{1'b1}}, 1'b1, {(LPW-1){1'b0}}};
                    end
                end
            endcase
        end

        assign splitNext[PW+i*GW +: GW] = laneNext[LAW-1:LPW];
        assign splitNext[i*LPW +: LPW]  = laneNext[LPW-1:0];

`ifdef MAC_OVF_FLAG_EN
        assign splitWrap[i] = (laneA[LAW-1] == laneP[LAW-1]) &&
                              (laneSum[LAW-1] != laneA[LAW-1]);
`endif
    end

    // Full-mode op: same operations over the whole {protect, result}
    always_comb begin
        fullNext = acc_q;
        case (s2Op)
            OP_CLEAR: fullNext = '0;
            OP_LOAD:  fullNext = fullProdExt;
            OP_MAC:   fullNext = fullSum;
            OP_SAT: begin
                if (!acc_q[AW-1] && (|acc_q[AW-2:PW-1])) begin
                    fullNext = {{GUARD_W{1'b0}}, 1'b0, {(PW-1){1'b1}}};
                end else if (acc_q[AW-1] && !(&acc_q[AW-2:PW-1])) begin
                    fullNext = {{GUARD_W{1'b1}}, 1'b1, {(PW-1){1'b0}}};
                end
            end
        endcase
    end

    // Accumulator next state: bubbles leave it untouched
    always_comb begin
        acc_d = acc_q;
        if (s2Valid_q) begin
            acc_d = s2Split ? splitNext : fullNext;
        end
    end

    // Pipeline and accumulator registers; reset wins over stall
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s1Valid_q  <= 1'b0;
            s1Instr_q  <= '0;
            s1Mplier_q <= '0;
            s1Mcand_q  <= '0;
            s2Valid_q  <= 1'b0;
            s2Instr_q  <= '0;
            s2Prod_q   <= '0;
            acc_q      <= '0;
            outValid_q <= 1'b0;
        end else begin
            outValid_q <= s2Valid_q & ~stall;
            if (!stall) begin
                s1Valid_q  <= in_valid;
                s1Instr_q  <= instruction;
                s1Mplier_q <= multiplier;
                s1Mcand_q  <= multiplicand;
                s2Valid_q  <= s1Valid_q;
                s2Instr_q  <= s1Instr_q;
                s2Prod_q   <= s2Prod_d;
                acc_q      <= acc_d;
            end
        end
    end

`ifdef MAC_OVF_FLAG_EN
    // Sticky overflow: set by a wrapping mac, cleared only by a clear op
    always_comb begin
        ovf_d = ovf_q;
        if (s2Valid_q) begin
            if (s2Op == OP_CLEAR) begin
                ovf_d = 1'b0;
            end else if (s2Op == OP_MAC) begin
                ovf_d = ovf_q | (s2Split ? (|splitWrap) : fullWrap);
            end
        end
    end

    // Overflow flag register, frozen by stall like the accumulator
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ovf_q <= 1'b0;
        end else if (!stall) begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

    assign result    = acc_q[PW-1:0];
    assign protect   = acc_q[AW-1:PW];
    assign out_valid = outValid_q;

endmodule

// File: tb/tb_simd_mac_pipe.sv
// Directed testbench for simd_mac_pipe (DATA_W=16, LANES=2, GUARD_W=8).
// Expected values are hand-computed constants.

module tb_simd_mac_pipe;

    logic        clk;
    logic        reset_n;
    logic        stall;
    logic        in_valid;
    logic [2:0]  instruction;
    logic [15:0] multiplier;
    logic [15:0] multiplicand;
    logic [31:0] result;
    logic [7:0]  protect;
    logic        out_valid;
    logic        ovf;

    int checkCount = 0;
    int passCount  = 0;

`ifdef MAC_OVF_FLAG_EN
    localparam logic OVF_ON_WRAP = 1'b1;
`else
    localparam logic OVF_ON_WRAP = 1'b0;
`endif

    simd_mac_pipe #(
        .DATA_W  (16),
        .LANES   (2),
        .GUARD_W (8)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .stall        (stall),
        .in_valid     (in_valid),
        .instruction  (instruction),
        .multiplier   (multiplier),
        .multiplicand (multiplicand),
        .result       (result),
        .protect      (protect),
        .out_valid    (out_valid),
        .ovf          (ovf)
    );

    // 100 MHz free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge and settle just after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one valid op for a single edge, then return to a bubble
    task automatic applyStimulus(input logic [2:0] instr,
                                 input logic [15:0] a,
                                 input logic [15:0] b);
        in_valid     = 1'b1;
        instruction  = instr;
        multiplier   = a;
        multiplicand = b;
        tick();
        in_valid     = 1'b0;
        instruction  = 3'b000;
    endtask

    task automatic checkOutput(input string tag,
                               input logic [63:0] observed,
                               input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end else begin
            passCount++;
        end
    endtask

    // Directed test sequence
    initial begin
        reset_n      = 1'b0;
        stall        = 1'b0;
        in_valid     = 1'b0;
        instruction  = 3'b000;
        multiplier   = 16'h0000;
        multiplicand = 16'h0000;
        #1;
        tick();
        tick();
        reset_n = 1'b1;

        checkOutput("reset_result",    64'(result),    64'h0);
        checkOutput("reset_protect",   64'(protect),   64'h0);
        checkOutput("reset_out_valid", 64'(out_valid), 64'h0);
        checkOutput("reset_ovf",       64'(ovf),       64'h0);

        // Full mul-load 0x7FFF*0x7FFF, lands on E2
        applyStimulus(3'b001, 16'h7FFF, 16'h7FFF);
        tick();
        checkOutput("t1_e1_result",    64'(result),    64'h0);
        checkOutput("t1_e1_out_valid", 64'(out_valid), 64'h0);
        tick();
        checkOutput("t1_result",       64'(result),    64'h3FFF0001);
        checkOutput("t1_protect",      64'(protect),   64'h00);
        checkOutput("t1_out_valid",    64'(out_valid), 64'h1);
        tick();
        checkOutput("t1_pulse_end",    64'(out_valid), 64'h0);

        // Full load + 2 mac of 0x8000*0x8000, then saturate positive
        applyStimulus(3'b001, 16'h8000, 16'h8000);
        applyStimulus(3'b010, 16'h8000, 16'h8000);
        applyStimulus(3'b010, 16'h8000, 16'h8000);
        tick();
        tick();
        checkOutput("t2_mac_result",  64'(result),  64'hC0000000);
        checkOutput("t2_mac_protect", 64'(protect), 64'h00);
        applyStimulus(3'b011, 16'h0000, 16'h0000);
        tick();
        tick();
        checkOutput("t2_sat_result",  64'(result),  64'h7FFFFFFF);
        checkOutput("t2_sat_protect", 64'(protect), 64'h00);

        // Full negative accumulation and saturate to min
        applyStimulus(3'b001, 16'h8000, 16'h7FFF);
        tick();
        tick();
        checkOutput("neg_load_result",  64'(result),  64'hC0008000);
        checkOutput("neg_load_protect", 64'(protect), 64'hFF);
        applyStimulus(3'b010, 16'h8000, 16'h7FFF);
        applyStimulus(3'b010, 16'h8000, 16'h7FFF);
        tick();
        tick();
        checkOutput("neg_mac_result",  64'(result),  64'h40018000);
        checkOutput("neg_mac_protect", 64'(protect), 64'hFF);
        applyStimulus(3'b011, 16'h0000, 16'h0000);
        tick();
        tick();
        checkOutput("neg_sat_result",  64'(result),  64'h80000000);
        checkOutput("neg_sat_protect", 64'(protect), 64'hFF);

        // Split mul-load: hi 2*3=6, lo -2*3=-6
        applyStimulus(3'b101, 16'h02FE, 16'h0303);
        tick();
        tick();
        checkOutput("t3_result",  64'(result),  64'h0006FFFA);
        checkOutput("t3_protect", 64'(protect), 64'h0F);

        // Stall 4 cycles while S2 holds a mac
        applyStimulus(3'b001, 16'h0003, 16'h0005);
        tick();
        tick();
        checkOutput("t4_load_result", 64'(result), 64'h0000000F);
        applyStimulus(3'b010, 16'h0002, 16'h0007);
        tick();
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput("t4_stall_result",    64'(result),    64'h0000000F);
            checkOutput("t4_stall_out_valid", 64'(out_valid), 64'h0);
        end
        stall = 1'b0;
        tick();
        checkOutput("t4_late_result",    64'(result),    64'h0000001D);
        checkOutput("t4_late_out_valid", 64'(out_valid), 64'h1);
        tick();
        checkOutput("t4_once_result",    64'(result),    64'h0000001D);
        checkOutput("t4_once_out_valid", 64'(out_valid), 64'h0);

        // Reset during stall with two ops in flight flushes them
        applyStimulus(3'b001, 16'h0001, 16'h0001);
        applyStimulus(3'b010, 16'h0001, 16'h0001);
        stall   = 1'b1;
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        stall   = 1'b0;
        checkOutput("t5_result",    64'(result),    64'h0);
        checkOutput("t5_protect",   64'(protect),   64'h0);
        checkOutput("t5_out_valid", 64'(out_valid), 64'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("t5_flush_out_valid", 64'(out_valid), 64'h0);
            checkOutput("t5_flush_result",    64'(result),    64'h0);
        end

        // Split lo-lane 0x80*0x80 accumulated until the 20-bit lane wraps
        applyStimulus(3'b101, 16'h0080, 16'h0080);
        for (int i = 0; i < 30; i++) begin
            applyStimulus(3'b110, 16'h0080, 16'h0080);
        end
        tick();
        tick();
        checkOutput("t6_pre_result",  64'(result),  64'h0000C000);
        checkOutput("t6_pre_protect", 64'(protect), 64'h07);
        checkOutput("t6_pre_ovf",     64'(ovf),     64'h0);
        applyStimulus(3'b110, 16'h0080, 16'h0080);
        tick();
        tick();
        checkOutput("t6_wrap_result",  64'(result),  64'h00000000);
        checkOutput("t6_wrap_protect", 64'(protect), 64'h08);
        checkOutput("t6_wrap_ovf",     64'(ovf),     64'(OVF_ON_WRAP));
        applyStimulus(3'b100, 16'h0000, 16'h0000);
        tick();
        tick();
        checkOutput("t6_clear_result",  64'(result),  64'h0);
        checkOutput("t6_clear_protect", 64'(protect), 64'h0);
        checkOutput("t6_clear_ovf",     64'(ovf),     64'h0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
